// File: rtl/regfile_writeback_queue_pkg.sv
// Shared widths and the queued-writeback entry type for regfile_writeback_queue.
package regfile_writeback_queue_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned AW       = 5;
    localparam int unsigned WB_DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_queue_if.sv
// Producer requests, register-file write port and decode lookup ports of the writeback queue.
interface regfile_writeback_queue_if
    import regfile_writeback_queue_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            mem_valid;
    logic [AW-1:0]   mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            mem_ready;
    logic            WE3;
    logic [AW-1:0]   A3;
    logic [XLEN-1:0] WD3;
    logic [AW-1:0]   chk_a1;
    logic [AW-1:0]   chk_a2;
    logic            hit1;
    logic            hit2;
    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;
    logic [CW-1:0]   count;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, chk_a1, chk_a2,
        input  alu_ready, mem_ready, WE3, A3, WD3, hit1, hit2, fwd1, fwd2, count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, chk_a1, chk_a2,
        output alu_ready, mem_ready, WE3, A3, WD3, hit1, hit2, fwd1, fwd2, count
    );

endinterface

// File: rtl/regfile_writeback_queue_wb_fifo.sv
// Circular writeback buffer: storage, pointers, occupancy and per-slot valid bits for lookup.
module wb_fifo
    import regfile_writeback_queue_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  wb_entry_t       push_entry,
    input  logic            pop,
    output wb_entry_t       entries [DEPTH],
    output logic [DEPTH-1:0] valid,
    output logic [PW-1:0]   head,
    output logic [CW-1:0]   count
);

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Payload is not reset; the valid vector alone qualifies every slot.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (push) begin
                wr_ptr        <= wr_ptr + 1'b1;
                valid[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + 1'b1;
                valid[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign entries = mem;
    assign head    = rd_ptr;

endmodule

// File: rtl/regfile_writeback_queue.sv
// Writeback queue in front of the 32x32 register file write port, with decode forwarding lookup.
// Optional macro WB_BYPASS_EN: an accepted request into an empty queue drives the write port directly.
module regfile_writeback_queue
    import regfile_writeback_queue_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input logic                      clk,
    input logic                      rst,
    regfile_writeback_queue_if.slave bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    head;
    logic [CW-1:0]    count;

    logic      full;
    logic      empty;
    logic      mem_acc;
    logic      alu_acc;
    logic      accept;
    logic      bypass;
    logic      push;
    logic      pop;
    wb_entry_t req;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Load has fixed priority; ready depends only on registered occupancy.
    assign mem_acc = bus.mem_valid & ~full & ~rst;
    assign alu_acc = bus.alu_valid & ~bus.mem_valid & ~full & ~rst;
    assign accept  = mem_acc | alu_acc;

    always_comb begin
        req = '0;
        if (bus.mem_valid) begin
            req.rd   = bus.mem_rd;
            req.data = bus.mem_data;
        end else begin
            req.rd   = bus.alu_rd;
            req.data = bus.alu_data;
        end
    end

`ifdef WB_BYPASS_EN
    assign bypass = accept & empty & (req.rd != '0);
`else
    assign bypass = 1'b0;
`endif

    assign push = accept & (req.rd != '0) & ~bypass;
    assign pop  = ~empty & ~rst;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (req),
        .pop        (pop),
        .entries    (entries),
        .valid      (valid),
        .head       (head),
        .count      (count)
    );

    assign bus.mem_ready = mem_acc;
    assign bus.alu_ready = alu_acc;
    assign bus.count     = count;

    always_comb begin
        bus.WE3 = 1'b0;
        bus.A3  = '0;
        bus.WD3 = '0;
        if (pop) begin
            bus.WE3 = 1'b1;
            bus.A3  = entries[head].rd;
            bus.WD3 = entries[head].data;
        end else if (bypass) begin
            bus.WE3 = 1'b1;
            bus.A3  = req.rd;
            bus.WD3 = req.data;
        end
    end

    logic [AW-1:0]   chk [2];
    logic            hit [2];
    logic [XLEN-1:0] fwd [2];
    logic [PW-1:0]   idx;

    assign chk[0] = bus.chk_a1;
    assign chk[1] = bus.chk_a2;

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        idx = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            hit[p] = 1'b0;
            fwd[p] = '0;
            if (!rst && chk[p] != '0) begin
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    idx = head + k[PW-1:0];
                    if (valid[idx] && entries[idx].rd == chk[p]) begin
                        hit[p] = 1'b1;
                        fwd[p] = entries[idx].data;
                    end
                end
                if (bypass && req.rd == chk[p]) begin
                    hit[p] = 1'b1;
                    fwd[p] = req.data;
                end
            end
        end
    end

    assign bus.hit1 = hit[0];
    assign bus.hit2 = hit[1];
    assign bus.fwd1 = fwd[0];
    assign bus.fwd2 = fwd[1];

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Self-checking bench for regfile_writeback_queue (default build) against a queue-based reference model.
module tb_regfile_writeback_queue;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_writeback_queue_if #(.DEPTH(DEPTH)) bus ();

    regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference lookup: the last matching queue element is the youngest.
    task automatic lookup(input bit r, input logic [4:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (!r && a != 5'd0) begin
            foreach (q[i]) begin
                if (q[i].rd == a) begin
                    h = 1'b1;
                    d = q[i].data;
                end
            end
        end
    endtask

    task automatic step(input bit r,
                        input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                        input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic [4:0] c1, input logic [4:0] c2);
        bit          full;
        logic        e_mr, e_ar, e_we, e_h1, e_h2;
        logic [4:0]  e_a3;
        logic [31:0] e_wd, e_f1, e_f2;
        ent_t        n;

        rst           = r;
        bus.mem_valid = mv;
        bus.mem_rd    = mrd;
        bus.mem_data  = md;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
        bus.chk_a1    = c1;
        bus.chk_a2    = c2;
        #3;

        full = (q.size() == DEPTH);
        e_mr = !r && mv && !full;
        e_ar = !r && av && !mv && !full;
        e_we = !r && q.size() > 0;
        e_a3 = e_we ? q[0].rd : 5'd0;
        e_wd = e_we ? q[0].data : 32'd0;
        lookup(r, c1, e_h1, e_f1);
        lookup(r, c2, e_h2, e_f2);

        check("mem_ready", 32'(bus.mem_ready), 32'(e_mr));
        check("alu_ready", 32'(bus.alu_ready), 32'(e_ar));
        check("WE3", 32'(bus.WE3), 32'(e_we));
        check("A3", 32'(bus.A3), 32'(e_a3));
        check("WD3", bus.WD3, e_wd);
        check("hit1", 32'(bus.hit1), 32'(e_h1));
        check("fwd1", bus.fwd1, e_f1);
        check("hit2", 32'(bus.hit2), 32'(e_h2));
        check("fwd2", bus.fwd2, e_f2);
        check("count", 32'(bus.count), q.size());

        if (r) begin
            q.delete();
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            if (e_mr && mrd != 5'd0) begin
                n.rd = mrd; n.data = md; q.push_back(n);
            end else if (e_ar && ard != 5'd0) begin
                n.rd = ard; n.data = ad; q.push_back(n);
            end
        end

        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] c1, input logic [4:0] c2);
        step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, c1, c2);
    endtask

    initial begin
        rst           = 1'b1;
        bus.mem_valid = 1'b0;
        bus.mem_rd    = '0;
        bus.mem_data  = '0;
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.chk_a1    = '0;
        bus.chk_a2    = '0;
        @(posedge clk);
        #1;

        // Reset state
        step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd5, 5'd3);

        // Single ALU request rd=5
        step(0, 0, 5'd0, 32'd0, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        idle(5'd5, 5'd0);
        idle(5'd5, 5'd0);

        // Both producers valid: load wins, ALU retries
        step(0, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 5'd3, 5'd4);
        step(0, 0, 5'd0, 32'd0, 1, 5'd4, 32'h22, 5'd3, 5'd4);
        idle(5'd3, 5'd4);
        idle(5'd3, 5'd4);

        // Back-to-back stream with the drain running
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 5'(i + 8), 32'(32'h100 + i), 1, 5'(i + 16), 32'(32'h200 + i),
                 5'(i + 7), 5'(i + 8));
        end
        idle(5'd13, 5'd0);
        idle(5'd13, 5'd0);

        // Two writes to x7, youngest forwarded
        step(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h1, 5'd7, 5'd7);
        step(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h2, 5'd7, 5'd7);
        idle(5'd7, 5'd7);
        idle(5'd7, 5'd7);

        // Write to x0 is acknowledged but never issued
        step(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);

        // Reset while writes are queued
        step(0, 1, 5'd1, 32'hA1, 0, 5'd0, 32'd0, 5'd1, 5'd2);
        step(0, 1, 5'd2, 32'hA2, 0, 5'd0, 32'd0, 5'd1, 5'd2);
        step(0, 1, 5'd3, 32'hA3, 0, 5'd0, 32'd0, 5'd2, 5'd3);
        step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd3, 5'd2);
        idle(5'd3, 5'd2);
        idle(5'd3, 5'd2);

        // Randomized traffic with a narrow register range to force lookup hits
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 1) == 0), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
- Writer-side front end for the processor's 32x32 register file.
- Accepts writeback requests from two producers, ALU and load/store, using valid/ready handshakes, and buffers them in a small FIFO.
- Drains the FIFO into the register file's single write port (WE3/A3/WD3), one write per cycle.
- Exposes two lookup ports so decode can detect and forward values that are still queued and not yet written.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- XLEN, 32, data width.
- AW, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- alu_valid  in  1  ALU request valid.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- mem_valid  in  1  load request valid.
- mem_rd  in  AW  load destination register.
- mem_data  in  XLEN  load data.
- mem_ready  out  1  load request accepted this cycle.
- WE3  out  1  register file write enable.
- A3  out  AW  register file write address.
- WD3  out  XLEN  register file write data.
- chk_a1, chk_a2  in  AW  lookup addresses (decode rs1/rs2).
- hit1, hit2  out  1  the queried register has a queued write.
- fwd1, fwd2  out  XLEN  data of the youngest queued write to that register.
- count  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset: all outputs are 0 at reset, including WE3, A3, WD3, hit*, fwd*, count and the *_ready outputs. Pointers are cleared.
  - Reset mid-operation discards all queued writes; none reach the register file.
- Arbitration:
  - At most one request is accepted per cycle. Load has fixed priority over ALU.
  - mem_ready = mem_valid & !full.
  - alu_ready = alu_valid & !mem_valid & !full.
  - full = (count == DEPTH). The full check uses registered count, so there is no combinational ready path through the pop.
- Enqueue: an accepted request with rd == 0 is acknowledged but not stored (x0 is hardwired). Otherwise {rd, data} is written at the tail and the tail pointer wraps modulo DEPTH.
- Drain:
  - When count > 0, WE3 = 1 and A3/WD3 = head entry, combinationally from the FIFO registers.
  - The head pops at the same clock edge at which the register file captures the write.
  - When empty, WE3 = 0 and A3/WD3 = 0.
- Latency: a request accepted at the edge ending cycle N appears on WE3 in cycle N+1. The register file is written at the end of N+1.
- Count: simultaneous push and pop leaves count unchanged. Push only increments it; pop only decrements it. Pop on empty and push on full cannot occur.
- Lookup (combinational):
  - hitK = 1 iff chk_aK != 0 and some valid entry, head included, has rd == chk_aK.
  - fwdK = data of the youngest such entry, nearest the tail. If hitK = 0, fwdK = 0.
  - The lookup does not include the request being accepted in the same cycle.
- Ordering: writes reach the register file in acceptance order. Two queued writes to the same register both issue; the later one wins.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when the FIFO is empty and a request with rd != 0 is accepted, it drives WE3/A3/WD3 in the same cycle and is not enqueued. Latency is 0 cycles. hit/fwd also match this bypassed request.
- Not defined: the behaviour above, with a minimum latency of 1 cycle.

Decomposition:
- Shared package: XLEN and AW constants, and a wb_entry_t typedef {rd[AW], data[XLEN]}.
- One natural sub-module, wb_fifo: storage, pointers, count, and per-entry valid vector exposed for lookup.
- The arbitration, drain and youngest-match priority search stay in the top level.

Test Plan:
- Reset mid-drain: queue 3 entries, assert rst for 1 cycle → WE3 = 0, count = 0 next cycle, no further register file writes.
- Single ALU request rd = 5, data = 0xDEADBEEF at cycle 0 → WE3 = 1, A3 = 5, WD3 = 0xDEADBEEF in cycle 1; count back to 0 in cycle 2.
- Both valid in the same cycle (mem rd = 3 / 0x11, alu rd = 4 / 0x22) → mem accepted first and alu_ready = 0; alu accepted next cycle; writes to 3 then 4 on consecutive cycles.
- Fill to DEPTH = 4 with the drain side observed → *_ready deasserts only while count == 4; no entry lost; write order matches acceptance order.
- Writes rd = 7 / 0x1 then rd = 7 / 0x2 queued, chk_a1 = 7 → hit1 = 1, fwd1 = 0x2; after both drain, hit1 = 0.
- Request with rd = 0, data = 0xFFFFFFFF → ready = 1, count stays 0, WE3 never asserted; chk_a1 = 0 → hit1 = 0.
